// File: rtl/down_cnt60_timer_pkg.sv
// Shared types and constants for the MM:SS BCD down-counter timer.
package down_cnt60_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] LO_MAX = 4'd9;
  localparam logic [2:0] HI_MAX = 3'd5;

  typedef struct packed {
    logic [2:0] mh;
    logic [3:0] ml;
    logic [2:0] sh;
    logic [3:0] sl;
  } mmss_t;

  localparam mmss_t MMSS_ZERO = '0;
  localparam mmss_t MMSS_ONE  = {3'd0, 4'd0, 3'd0, 4'd1};
  localparam mmss_t MMSS_MAX  = {HI_MAX, LO_MAX, HI_MAX, LO_MAX};

  // Out-of-range digits saturate to their digit maximum rather than wrapping.
  function automatic mmss_t clamp_mmss(mmss_t v);
    mmss_t r;
    r.mh = (v.mh > MMSS_MAX.mh) ? MMSS_MAX.mh : v.mh;
    r.ml = (v.ml > MMSS_MAX.ml) ? MMSS_MAX.ml : v.ml;
    r.sh = (v.sh > MMSS_MAX.sh) ? MMSS_MAX.sh : v.sh;
    r.sl = (v.sl > MMSS_MAX.sl) ? MMSS_MAX.sl : v.sl;
    return r;
  endfunction

endpackage

// File: rtl/dcnt60_stage.sv
// One mod-60 BCD down stage (tens 0..5, units 0..9) with load and a
// combinational borrow-out that feeds the next stage's decrement.
module dcnt60_stage
  import down_cnt60_timer_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [2:0] ld_hi_i,
  input  logic [3:0] ld_lo_i,
  input  logic       dec_i,
  output logic [2:0] hi_o,
  output logic [3:0] lo_o,
  output logic       zero_o,
  output logic       bo_o
);

  logic [2:0] hi_q, hi_d;
  logic [3:0] lo_q, lo_d;

  assign zero_o = (hi_q == 3'd0) && (lo_q == 4'd0);
  assign bo_o   = dec_i && zero_o;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_i) begin
      hi_d = ld_hi_i;
      lo_d = ld_lo_i;
    end else if (dec_i) begin
      if (lo_q == 4'd0) begin
        lo_d = LO_MAX;
        hi_d = (hi_q == 3'd0) ? HI_MAX : hi_q - 3'd1;
      end else begin
        lo_d = lo_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= 3'd0;
      lo_q <= 4'd0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

endmodule

// File: rtl/down_cnt60_timer.sv
// MM:SS BCD countdown timer with preset, pause/resume, manual step and
// optional auto-reload on expiry. All outputs come straight from flops.
module down_cnt60_timer
  import down_cnt60_timer_pkg::*;
#(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       EN,
  input  logic       DEC,
  input  logic       LOAD,
  input  logic       START,
  input  logic       STOP,
  input  logic [2:0] PMH,
  input  logic [3:0] PML,
  input  logic [2:0] PSH,
  input  logic [3:0] PSL,
  output logic [2:0] QMH,
  output logic [3:0] QML,
  output logic [2:0] QSH,
  output logic [3:0] QSL,
  output logic       BUSY,
  output logic       EXP,
  output logic       DONE,
  output logic       BR
);

  state_e state_q, state_d;
  mmss_t  pre_q, pre_d;
  mmss_t  preset_in, cnt, cnt_ld_val;
  logic   busy_q, exp_q, done_q, done_d, br_q;
  logic   cnt_ld, dec_en, cnt_zero, cnt_one, idle_or_pause;
  logic   sec_zero, sec_bo, min_zero, unused_min_bo;
  logic [2:0] sec_hi, min_hi;
  logic [3:0] sec_lo, min_lo;

  assign preset_in     = clamp_mmss({PMH, PML, PSH, PSL});
  assign cnt           = {min_hi, min_lo, sec_hi, sec_lo};
  assign cnt_zero      = sec_zero && min_zero;
  assign cnt_one       = (cnt == MMSS_ONE);
  assign idle_or_pause = (state_q == ST_IDLE) || (state_q == ST_PAUSE);

  // Seconds borrow drives the minutes decrement; the minutes borrow can only
  // fire from 00:00, which the control never decrements.
  dcnt60_stage u_sec (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (cnt_ld),
    .ld_hi_i(cnt_ld_val.sh),
    .ld_lo_i(cnt_ld_val.sl),
    .dec_i  (dec_en),
    .hi_o   (sec_hi),
    .lo_o   (sec_lo),
    .zero_o (sec_zero),
    .bo_o   (sec_bo)
  );

  dcnt60_stage u_min (
    .clk_i  (CLK),
    .rst_i  (RST),
    .load_i (cnt_ld),
    .ld_hi_i(cnt_ld_val.mh),
    .ld_lo_i(cnt_ld_val.ml),
    .dec_i  (sec_bo),
    .hi_o   (min_hi),
    .lo_o   (min_lo),
    .zero_o (min_zero),
    .bo_o   (unused_min_bo)
  );

  // Strict priority on raw inputs: a higher command masks all lower ones
  // even when it has no effect in the current state.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_ld     = 1'b0;
    cnt_ld_val = pre_q;
    dec_en     = 1'b0;
    done_d     = 1'b0;
    if (CLR) begin
      pre_d      = MMSS_ZERO;
      cnt_ld     = 1'b1;
      cnt_ld_val = MMSS_ZERO;
      state_d    = ST_IDLE;
    end else if (LOAD) begin
      if (state_q != ST_RUN) begin
        pre_d      = preset_in;
        cnt_ld     = 1'b1;
        cnt_ld_val = preset_in;
        state_d    = ST_IDLE;
      end
    end else if (STOP) begin
      if (state_q == ST_RUN) state_d = ST_PAUSE;
    end else if (START) begin
      if (idle_or_pause && !cnt_zero) state_d = ST_RUN;
    end else if (EN && state_q == ST_RUN) begin
      if (cnt_one) begin
        done_d = 1'b1;
        if (AUTO_RELOAD && pre_q != MMSS_ZERO) begin
          cnt_ld = 1'b1;
        end else begin
          dec_en  = 1'b1;
          state_d = ST_EXPIRED;
        end
      end else begin
        dec_en = 1'b1;
      end
    end else if (DEC && idle_or_pause && !cnt_zero) begin
      dec_en = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      pre_q   <= MMSS_ZERO;
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
      done_q  <= 1'b0;
      br_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      busy_q  <= (state_d == ST_RUN);
      exp_q   <= (state_d == ST_EXPIRED);
      done_q  <= done_d;
      br_q    <= sec_bo;
    end
  end

  assign QMH  = min_hi;
  assign QML  = min_lo;
  assign QSH  = sec_hi;
  assign QSL  = sec_lo;
  assign BUSY = busy_q;
  assign EXP  = exp_q;
  assign DONE = done_q;
  assign BR   = br_q;

endmodule
